rst_on_lut_pipe_nbit: RTL and testbench
=======================================

Name: rst_on_lut_pipe_nbit

Overview:
- Parametrised successor to the single-bit reset-on-LUT micro-benchmark.
- WIDTH-bit registered datapath, DEPTH stages deep, with valid tracking and a wrapping output-sample counter.
- All state is cleared by the asynchronous reset.
- Also provides a WIDTH-bit combinational gate of b by rst, polarity set by GATE_MODE. This exercises reset-net routing into both FF async-reset pins and LUT inputs.

Parameters:
- WIDTH, 4, data/channel width; must be >= 1.
- DEPTH, 2, register stages from a to q; must be >= 1.
- CNT_W, 3, width of the valid-sample counter; must be >= 1.
- RST_VAL, 0, value every data stage (and therefore q) takes during reset; WIDTH bits, zero-extended.
- GATE_MODE, 0, 0: out = b AND NOT rst; 1: out = b OR rst (bitwise replicated).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset; clock clk
- in_valid  input  1  a is valid this cycle
- a  input  WIDTH  pipeline data input
- b  input  WIDTH  combinational gate data input
- q  output  WIDTH  pipeline data output (last stage register)
- q_valid  output  1  q holds a valid sample
- cnt  output  CNT_W  number of cycles with q_valid=1, modulo 2^CNT_W
- out  output  WIDTH  gated b (see GATE_MODE)

Behaviour:
- Reset (rst=1, asynchronous, takes effect without a clock edge):
  - all data stages = RST_VAL, so q = RST_VAL;
  - valid shift register = 0, so q_valid = 0;
  - cnt = 0.
  - out is combinational: 0 if GATE_MODE=0, all-ones if GATE_MODE=1.
- Reset release: first capturing edge is the first rising clk edge with rst=0; no synchronous release logic inside the block.
- Data pipeline (every rising clk edge, rst=0):
  - stage[0] <= a when in_valid=1, otherwise holds;
  - stage[k] <= stage[k-1] when vld[k-1]=1, otherwise holds, for k=1..DEPTH-1;
  - q = stage[DEPTH-1].
- Valid pipeline:
  - vld[0] <= in_valid; vld[k] <= vld[k-1]; no stall, advances every cycle;
  - q_valid = vld[DEPTH-1].
- Latency: a sample presented with in_valid=1 at edge N appears on q, with q_valid=1, after edge N+DEPTH-1, i.e. DEPTH cycles after presentation.
- Data hold: when q_valid=0, q holds the last valid sample, or RST_VAL if none since reset.
- Counter: cnt <= cnt+1 on each edge where q_valid=1 before the edge. Wraps from 2^CNT_W-1 to 0 with no flag.
- Gate: out is purely combinational, zero latency. It reflects rst mid-cycle, independent of clk.
- Reset mid-operation:
  - in-flight samples are discarded;
  - q_valid drops to 0 immediately on rst assertion;
  - cnt returns to 0;
  - no partial sample emerges after release.
- Back-to-back: in_valid held high for M cycles yields M consecutive q_valid cycles carrying samples in order.
- DEPTH=1 degenerates to one register, functionally identical to the original single-bit block when WIDTH=1 and in_valid=1, with out gated by rst.

Test Plan:
- (WIDTH=4, DEPTH=2, CNT_W=3, RST_VAL=0, GATE_MODE=0) Assert rst with clk idle; b=4'hF:
  - q=0, q_valid=0, cnt=0 immediately;
  - out=0;
  - after release, out=4'hF with no clock edge.
- Single sample: in_valid=1, a=4'hA for one cycle, then in_valid=0, a=4'h5:
  - q_valid=1 exactly one cycle, 2 edges after presentation, with q=4'hA;
  - q stays 4'hA afterwards;
  - cnt=1 afterwards.
- Stream of 9 samples 1..9, in_valid held high:
  - q shows 1..9 in order on consecutive cycles;
  - cnt wraps 7->0 and ends at 1.
- Reset mid-stream: pulse rst for half a cycle while samples 3 and 4 are in flight:
  - q=0 and q_valid=0 immediately, cnt=0;
  - samples 3 and 4 never appear on q after release.
- GATE_MODE=1, RST_VAL=4'h6:
  - during reset, q=4'h6 and out=4'hF for b=4'h2;
  - after release, out=4'h2.
- Gap handling: samples with in_valid pattern 1,0,1 (a=4'h1, x, 4'h3):
  - q_valid pattern 1,0,1 with q=4'h1, holds 4'h1, then 4'h3.

Source files
------------

// File: rtl/rst_on_lut_pipe_nbit.sv
// WIDTH-bit registered pipeline with valid tracking and a wrapping sample counter,
// plus a combinational rst gate on b. rst drives both FF async pins and LUT inputs.
module rst_on_lut_pipe_nbit #(
  parameter int               WIDTH     = 4,
  parameter int               DEPTH     = 2,
  parameter int               CNT_W     = 3,
  parameter logic [WIDTH-1:0] RST_VAL   = '0,
  parameter int               GATE_MODE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  output logic [CNT_W-1:0] cnt,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] stage [DEPTH];
  logic [DEPTH-1:0] vld;

  // Data stages only move when their upstream stage holds a valid sample,
  // so q keeps the last valid sample across gaps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) stage[k] <= RST_VAL;
      vld <= '0;
    end else begin
      if (in_valid) stage[0] <= a;
      for (int k = 1; k < DEPTH; k++) begin
        if (vld[k-1]) stage[k] <= stage[k-1];
      end
      vld[0] <= in_valid;
      for (int k = 1; k < DEPTH; k++) vld[k] <= vld[k-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          cnt <= '0;
    else if (q_valid) cnt <= cnt + CNT_W'(1);
  end

  assign q       = stage[DEPTH-1];
  assign q_valid = vld[DEPTH-1];

  generate
    if (GATE_MODE == 0) begin : g_and
      assign out = b & ~{WIDTH{rst}};
    end else begin : g_or
      assign out = b | {WIDTH{rst}};
    end
  endgenerate

endmodule

// File: tb/tb_rst_on_lut_pipe_nbit.sv
// Bench for rst_on_lut_pipe_nbit: fixed vector table, hand sequences and a
// randomized run against a queue-based delivery model, on two parameter sets.
module tb_rst_on_lut_pipe_nbit;
  localparam int DEPTH = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] a = '0;
  logic [3:0] b = '0;
  logic [3:0] q0, q1, out0, out1;
  logic       qv0, qv1;
  logic [2:0] cnt0, cnt1;

  rst_on_lut_pipe_nbit #(.WIDTH(4), .DEPTH(DEPTH), .CNT_W(3), .RST_VAL(4'h0), .GATE_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
    .q(q0), .q_valid(qv0), .cnt(cnt0), .out(out0));

  rst_on_lut_pipe_nbit #(.WIDTH(4), .DEPTH(DEPTH), .CNT_W(3), .RST_VAL(4'h6), .GATE_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
    .q(q1), .q_valid(qv1), .cnt(cnt1), .out(out1));

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  // Reference: each accepted sample is scheduled for delivery DEPTH-1 edges later.
  typedef struct { logic [3:0] d; int due; } fl_t;
  fl_t        fq[$];
  int         ec = 0;
  bit         m_qv = 0;
  bit         m_has = 0;
  logic [3:0] m_last = '0;
  int         m_cnt = 0;

  function automatic void model_reset();
    fq.delete();
    m_qv = 0; m_has = 0; m_cnt = 0;
  endfunction

  function automatic void model_edge(input bit iv, input logic [3:0] d);
    fl_t t;
    if (m_qv) m_cnt = (m_cnt + 1) % 8;
    if (iv) fq.push_back('{d, ec + DEPTH - 1});
    m_qv = 0;
    if (fq.size() > 0 && fq[0].due == ec) begin
      t = fq.pop_front();
      m_last = t.d; m_has = 1; m_qv = 1;
    end
    ec++;
  endfunction

  function automatic logic [3:0] mq(input logic [3:0] rv);
    return m_has ? m_last : rv;
  endfunction

  task automatic tick(input bit iv, input logic [3:0] d);
    #4 clk = 1'b0;
    in_valid = iv; a = d;
    #5 clk = 1'b1;
    model_edge(iv, d);
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".q0"}, 32'(q0), 32'(mq(4'h0)));
    chk({tag, ".qv0"}, 32'(qv0), 32'(m_qv));
    chk({tag, ".cnt0"}, 32'(cnt0), 32'(m_cnt));
    chk({tag, ".q1"}, 32'(q1), 32'(mq(4'h6)));
    chk({tag, ".qv1"}, 32'(qv1), 32'(m_qv));
    chk({tag, ".cnt1"}, 32'(cnt1), 32'(m_cnt));
    chk({tag, ".out0"}, 32'(out0), 32'(rst ? 4'h0 : b));
    chk({tag, ".out1"}, 32'(out1), 32'(rst ? 4'hF : b));
  endtask

  task automatic pulse_reset();
    #1 rst = 1'b1;
    model_reset();
    #1;
    chk("rstpulse.q0", 32'(q0), 32'h0);
    chk("rstpulse.qv0", 32'(qv0), 32'h0);
    chk("rstpulse.cnt0", 32'(cnt0), 32'h0);
    chk("rstpulse.out0", 32'(out0), 32'h0);
    chk("rstpulse.q1", 32'(q1), 32'h6);
    chk("rstpulse.out1", 32'(out1), 32'hF);
    rst = 1'b0;
    #1;
  endtask

  typedef struct {
    bit iv; logic [3:0] a;
    bit qv; logic [3:0] q; logic [2:0] cnt;
  } vec_t;
  vec_t tbl[9];

  initial begin
    // Single sample 4'hA, then gap pattern 1,0,1 with 4'h1, x, 4'h3.
    tbl[0] = '{1'b1, 4'hA, 1'b0, 4'h0, 3'd0};
    tbl[1] = '{1'b0, 4'h5, 1'b1, 4'hA, 3'd0};
    tbl[2] = '{1'b0, 4'h5, 1'b0, 4'hA, 3'd1};
    tbl[3] = '{1'b0, 4'h5, 1'b0, 4'hA, 3'd1};
    tbl[4] = '{1'b1, 4'h1, 1'b0, 4'hA, 3'd1};
    tbl[5] = '{1'b0, 4'h7, 1'b1, 4'h1, 3'd1};
    tbl[6] = '{1'b1, 4'h3, 1'b0, 4'h1, 3'd2};
    tbl[7] = '{1'b0, 4'h9, 1'b1, 4'h3, 3'd2};
    tbl[8] = '{1'b0, 4'h9, 1'b0, 4'h3, 3'd3};

    // Reset with clock idle.
    b = 4'hF;
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk("idle_rst.q0", 32'(q0), 32'h0);
    chk("idle_rst.qv0", 32'(qv0), 32'h0);
    chk("idle_rst.cnt0", 32'(cnt0), 32'h0);
    chk("idle_rst.out0", 32'(out0), 32'h0);
    chk("idle_rst.q1", 32'(q1), 32'h6);
    b = 4'h2;
    #1;
    chk("idle_rst.out1", 32'(out1), 32'hF);
    b = 4'hF;
    rst = 1'b0;
    #1;
    chk("release.out0", 32'(out0), 32'hF);
    b = 4'h2;
    #1;
    chk("release.out1", 32'(out1), 32'h2);

    for (int i = 0; i < 9; i++) begin
      tick(tbl[i].iv, tbl[i].a);
      chk($sformatf("vec%0d.qv", i), 32'(qv0), 32'(tbl[i].qv));
      chk($sformatf("vec%0d.q", i), 32'(q0), 32'(tbl[i].q));
      chk($sformatf("vec%0d.cnt", i), 32'(cnt0), 32'(tbl[i].cnt));
    end

    // Stream 1..9 back-to-back: cnt wraps 7->0 and ends at 1.
    pulse_reset();
    for (int i = 0; i <= 10; i++) begin
      tick(i < 9, 4'(i + 1));
      chk($sformatf("stream%0d.qv", i), 32'(qv0), 32'((i >= 1 && i <= 9) ? 1 : 0));
      chk($sformatf("stream%0d.q", i), 32'(q0), 32'((i == 0) ? 0 : (i > 9 ? 9 : i)));
      chk($sformatf("stream%0d.cnt", i), 32'(cnt0), 32'((i >= 2) ? (i - 1) % 8 : 0));
    end

    // Reset mid-stream: sample 3 captured, 4 pending; neither may emerge.
    pulse_reset();
    for (int i = 0; i < 3; i++) tick(1'b1, 4'(i + 1));
    chk("mid.q_before", 32'(q0), 32'h2);
    in_valid = 1'b1; a = 4'h4;
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 4'h4);
      chk($sformatf("mid%0d.qv", i), 32'(qv0), 32'h0);
      chk($sformatf("mid%0d.q", i), 32'(q0), 32'h0);
      chk($sformatf("mid%0d.cnt", i), 32'(cnt0), 32'h0);
      chk($sformatf("mid%0d.q1", i), 32'(q1), 32'h6);
    end

    // Randomized run with occasional reset pulses.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        pulse_reset();
      end else begin
        b = 4'($urandom_range(0, 15));
        tick(1'($urandom_range(0, 2) != 0), 4'($urandom_range(0, 15)));
        check_model($sformatf("rand%0d", i));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
